dbg_ctrl_sel: RTL and testbench

- Parametrised control-source selector between the board inputs and the VIO, placed in front of qpsk_comm_sys in the debug top.
- Synchronises and debounces the physical reset and switches.
- Switches control source with a clean handover that holds the comm system in reset.
- Stretches reset to a minimum width.
- Keeps live and sticky copies of the comm-system status flags for the LEDs and ILA/VIO probes.

---
 rtl/dbg_ctrl_sel.sv | 215 +++++++++++++++++++++
 tb/tb_dbg_ctrl_sel.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_ctrl_sel.sv
// dbg_ctrl_sel: chooses whether the board pins or the VIO drive the comm system.
// Physical inputs are synchronised and debounced. A change of source goes through
// a handover that holds the comm system in reset. Reset is stretched to a minimum
// width, and the status flags are kept as live and sticky-lost copies.
//
// Ports:
//   clk          system clock
//   i_reset      asynchronous active-low block reset
//   i_sel_vio    source select (1 = VIO, 0 = physical), clk domain
//   i_phy_reset  physical reset button, asynchronous, active-high
//   i_phy_ctrl   physical switches, asynchronous
//   i_vio_reset  VIO reset request, active-high
//   i_vio_ctrl   VIO control bits
//   i_stat       comm-system status flags
//   i_stat_clr   sticky-clear, acts on its rising edge
//   o_sys_reset  active-high reset to the comm system
//   o_ctrl       selected control bits
//   o_stat_live  i_stat delayed by one cycle
//   o_stat_lost  sticky: status bit fell 1->0 outside reset
//   o_src_vio    effective source (1 = VIO)
//   o_switching  high during a handover
module dbg_ctrl_sel #(
  parameter int unsigned NB_CTRL      = 2,
  parameter int unsigned NB_STAT      = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned RST_STRETCH  = 8
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_sel_vio,
  input  logic               i_phy_reset,
  input  logic [NB_CTRL-1:0] i_phy_ctrl,
  input  logic               i_vio_reset,
  input  logic [NB_CTRL-1:0] i_vio_ctrl,
  input  logic [NB_STAT-1:0] i_stat,
  input  logic               i_stat_clr,
  output logic               o_sys_reset,
  output logic [NB_CTRL-1:0] o_ctrl,
  output logic [NB_STAT-1:0] o_stat_live,
  output logic [NB_STAT-1:0] o_stat_lost,
  output logic               o_src_vio,
  output logic               o_switching
);

  // The physical reset button is debounced alongside the switches, as the top bit.
  localparam int unsigned NB_PHY = NB_CTRL + 1;
  localparam int unsigned CNT_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned STR_W  = $clog2(RST_STRETCH + 1);

  typedef enum logic [1:0] {
    SRC_PHY  = 2'd0,
    SRC_VIO  = 2'd1,
    HANDOVER = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0][NB_PHY-1:0] sync_q;
  logic [NB_PHY-1:0]                  synced;
  logic [NB_PHY-1:0]                  deb_q;
  logic [NB_PHY-1:0][CNT_W-1:0]       deb_cnt_q;

  state_t             state_q, state_n;
  logic               target_q, target_n;
  logic [STR_W-1:0]   ho_cnt_q, ho_cnt_n;
  logic [STR_W-1:0]   stretch_q, stretch_n;
  logic               req;
  logic               sys_reset_n;
  logic               switching_n;
  logic               src_vio_n;
  logic [NB_CTRL-1:0] ctrl_n;
  logic               clr_q;
  logic               clr_rise;
  logic [NB_STAT-1:0] lost_set;
  logic [NB_STAT-1:0] lost_n;

  assign synced = sync_q[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous pins.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {i_phy_reset, i_phy_ctrl}};
    end
  end

  // Per-bit debounce. A new level is accepted only after it has been seen on
  // DEBOUNCE_CYC consecutive cycles; any cycle back at the old level restarts the count.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      deb_q     <= '0;
      deb_cnt_q <= '0;
    end else begin
      for (int unsigned b = 0; b < NB_PHY; b++) begin
        if (synced[b] != deb_q[b]) begin
          if (deb_cnt_q[b] == CNT_W'(DEBOUNCE_CYC - 1)) begin
            deb_q[b]     <= synced[b];
            deb_cnt_q[b] <= '0;
          end else begin
            deb_cnt_q[b] <= deb_cnt_q[b] + CNT_W'(1);
          end
        end else begin
          deb_cnt_q[b] <= '0;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= SRC_PHY;
    end else begin
      state_q <= state_n;
    end
  end

  // Next state, reset request and the next values of the registered outputs.
  always_comb begin
    state_n  = state_q;
    target_n = target_q;
    ho_cnt_n = ho_cnt_q;
    req      = 1'b0;

    case (state_q)
      SRC_PHY: begin
        if (i_sel_vio) begin
          state_n  = HANDOVER;
          target_n = 1'b1;
          ho_cnt_n = STR_W'(RST_STRETCH);
        end
      end
      SRC_VIO: begin
        if (!i_sel_vio) begin
          state_n  = HANDOVER;
          target_n = 1'b0;
          ho_cnt_n = STR_W'(RST_STRETCH);
        end
      end
      HANDOVER: begin
        // A reversed select restarts the full handover toward the new target.
        if (i_sel_vio != target_q) begin
          target_n = i_sel_vio;
          ho_cnt_n = STR_W'(RST_STRETCH);
        end else if (ho_cnt_q <= STR_W'(1)) begin
          state_n = target_q ? SRC_VIO : SRC_PHY;
        end else begin
          ho_cnt_n = ho_cnt_q - STR_W'(1);
        end
      end
      default: state_n = SRC_PHY;
    endcase

    // A handover beginning this cycle takes priority over any reset request.
    if (state_n != HANDOVER) begin
      if (state_q == SRC_VIO) begin
        req = i_vio_reset;
      end else if (state_q == SRC_PHY) begin
        req = deb_q[NB_CTRL];
      end
    end

    if (req) begin
      stretch_n = STR_W'(RST_STRETCH);
    end else if (stretch_q != '0) begin
      stretch_n = stretch_q - STR_W'(1);
    end else begin
      stretch_n = '0;
    end

    sys_reset_n = req | (stretch_q != '0) | (state_n == HANDOVER);
    switching_n = (state_n == HANDOVER);
    src_vio_n   = (state_n == SRC_VIO) | ((state_n == HANDOVER) & target_n);

    // Control bits freeze for the whole handover.
    case (state_q)
      SRC_VIO: ctrl_n = i_vio_ctrl;
      SRC_PHY: ctrl_n = deb_q[NB_CTRL-1:0];
      default: ctrl_n = o_ctrl;
    endcase

    // Sticky lost flags: a new set wins over a clear in the same cycle.
    clr_rise = i_stat_clr & ~clr_q;
    lost_set = o_stat_live & ~i_stat & {NB_STAT{~o_sys_reset}};
    lost_n   = lost_set | (o_stat_lost & ~{NB_STAT{clr_rise | o_sys_reset}});
  end

  // Handover bookkeeping, stretch counter and registered outputs.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      target_q    <= 1'b0;
      ho_cnt_q    <= '0;
      stretch_q   <= STR_W'(RST_STRETCH);
      o_sys_reset <= 1'b1;
      o_switching <= 1'b0;
      o_src_vio   <= 1'b0;
      o_ctrl      <= '0;
      o_stat_live <= '0;
      o_stat_lost <= '0;
      clr_q       <= 1'b0;
    end else begin
      target_q    <= target_n;
      ho_cnt_q    <= ho_cnt_n;
      stretch_q   <= stretch_n;
      o_sys_reset <= sys_reset_n;
      o_switching <= switching_n;
      o_src_vio   <= src_vio_n;
      o_ctrl      <= ctrl_n;
      o_stat_live <= i_stat;
      o_stat_lost <= lost_n;
      clr_q       <= i_stat_clr;
    end
  end

endmodule

// File: tb/tb_dbg_ctrl_sel.sv
// Scoreboard bench for dbg_ctrl_sel: the stimulus queues expected output values
// tagged with the clock cycle they must appear in; a monitor on the falling edge
// pulls every entry due in that cycle and compares it against the DUT.
module tb_dbg_ctrl_sel;

  localparam int unsigned NB_CTRL = 2;
  localparam int unsigned NB_STAT = 4;

  localparam int ID_RST  = 0;
  localparam int ID_CTRL = 1;
  localparam int ID_LIVE = 2;
  localparam int ID_LOST = 3;
  localparam int ID_SRC  = 4;
  localparam int ID_SW   = 5;

  logic               clk = 1'b0;
  logic               i_reset;
  logic               i_sel_vio;
  logic               i_phy_reset;
  logic [NB_CTRL-1:0] i_phy_ctrl;
  logic               i_vio_reset;
  logic [NB_CTRL-1:0] i_vio_ctrl;
  logic [NB_STAT-1:0] i_stat;
  logic               i_stat_clr;
  logic               o_sys_reset;
  logic [NB_CTRL-1:0] o_ctrl;
  logic [NB_STAT-1:0] o_stat_live;
  logic [NB_STAT-1:0] o_stat_lost;
  logic               o_src_vio;
  logic               o_switching;

  typedef struct {
    int         cyc;
    int         id;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  dbg_ctrl_sel #(
    .NB_CTRL(NB_CTRL), .NB_STAT(NB_STAT), .SYNC_STAGES(2),
    .DEBOUNCE_CYC(16), .RST_STRETCH(8)
  ) dut (
    .clk(clk), .i_reset(i_reset), .i_sel_vio(i_sel_vio),
    .i_phy_reset(i_phy_reset), .i_phy_ctrl(i_phy_ctrl),
    .i_vio_reset(i_vio_reset), .i_vio_ctrl(i_vio_ctrl),
    .i_stat(i_stat), .i_stat_clr(i_stat_clr),
    .o_sys_reset(o_sys_reset), .o_ctrl(o_ctrl),
    .o_stat_live(o_stat_live), .o_stat_lost(o_stat_lost),
    .o_src_vio(o_src_vio), .o_switching(o_switching)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] act(int id);
    case (id)
      ID_RST:  return 8'(o_sys_reset);
      ID_CTRL: return 8'(o_ctrl);
      ID_LIVE: return 8'(o_stat_live);
      ID_LOST: return 8'(o_stat_lost);
      ID_SRC:  return 8'(o_src_vio);
      default: return 8'(o_switching);
    endcase
  endfunction

  function automatic string nm(int id);
    case (id)
      ID_RST:  return "sys_reset";
      ID_CTRL: return "ctrl";
      ID_LIVE: return "stat_live";
      ID_LOST: return "stat_lost";
      ID_SRC:  return "src_vio";
      default: return "switching";
    endcase
  endfunction

  task automatic push_exp(int id, int at, logic [7:0] v);
    exp_t e;
    e.cyc = at;
    e.id  = id;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every entry due in the current cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        n_vec++;
        if (act(sb[i].id) !== sb[i].val) begin
          n_err++;
          $display("FAIL %s cycle %0d: got %0h, want %0h", nm(sb[i].id), cyc,
                   act(sb[i].id), sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL %s cycle %0d: not sampled, want %0h", nm(sb[i].id), sb[i].cyc,
                 sb[i].val);
        sb.delete(i);
      end
    end
  end

  initial begin
    int r, p, g, q, h, v, s, y;
    i_reset     = 1'b0;
    i_sel_vio   = 1'b0;
    i_phy_reset = 1'b0;
    i_phy_ctrl  = '0;
    i_vio_reset = 1'b0;
    i_vio_ctrl  = '0;
    i_stat      = '0;
    i_stat_clr  = 1'b0;

    // Reset values while i_reset is held low.
    step(3);
    push_exp(ID_RST,  cyc + 1, 8'd1);
    push_exp(ID_CTRL, cyc + 1, 8'd0);
    push_exp(ID_LIVE, cyc + 1, 8'd0);
    push_exp(ID_LOST, cyc + 1, 8'd0);
    push_exp(ID_SRC,  cyc + 1, 8'd0);
    push_exp(ID_SW,   cyc + 1, 8'd0);
    step(2);

    // Release: sys_reset high for 8 cycles, then low.
    r = cyc;
    i_reset = 1'b1;
    for (int k = 1; k <= 9; k++) push_exp(ID_RST, r + k, (k <= 8) ? 8'd1 : 8'd0);
    step(12);

    // Physical switch: 2 sync + 16 debounce + 1 output register.
    p = cyc;
    i_phy_ctrl = 2'b01;
    push_exp(ID_CTRL, p + 18, 8'd1 - 8'd1);
    push_exp(ID_CTRL, p + 19, 8'd1);
    push_exp(ID_SRC,  p + 19, 8'd0);
    step(30);

    // A 10-cycle glitch to 2'b10 is rejected.
    g = cyc;
    i_phy_ctrl = 2'b10;
    push_exp(ID_CTRL, g + 5,  8'd1);
    push_exp(ID_CTRL, g + 20, 8'd1);
    step(10);
    i_phy_ctrl = 2'b01;
    push_exp(ID_CTRL, cyc + 20, 8'd1);
    push_exp(ID_CTRL, cyc + 30, 8'd1);
    step(35);

    // Physical reset held for 40 cycles.
    q = cyc;
    i_phy_reset = 1'b1;
    push_exp(ID_RST, q + 18, 8'd0);
    push_exp(ID_RST, q + 19, 8'd1);
    step(40);
    i_phy_reset = 1'b0;
    push_exp(ID_RST, q + 58, 8'd1);
    push_exp(ID_RST, q + 66, 8'd1);
    push_exp(ID_RST, q + 67, 8'd0);
    step(35);

    // Handover toward VIO reversed at handover cycle 4: ends back on physical.
    h = cyc;
    i_vio_ctrl = 2'b11;
    i_sel_vio  = 1'b1;
    push_exp(ID_SW,   h + 1,  8'd1);
    push_exp(ID_SRC,  h + 1,  8'd1);
    push_exp(ID_RST,  h + 1,  8'd1);
    push_exp(ID_SRC,  h + 4,  8'd1);
    push_exp(ID_SRC,  h + 5,  8'd0);
    push_exp(ID_SW,   h + 12, 8'd1);
    push_exp(ID_RST,  h + 12, 8'd1);
    push_exp(ID_SW,   h + 13, 8'd0);
    push_exp(ID_RST,  h + 13, 8'd0);
    push_exp(ID_SRC,  h + 13, 8'd0);
    push_exp(ID_CTRL, h + 14, 8'd1);
    step(4);
    i_sel_vio = 1'b0;
    step(20);

    // Clean handover to VIO.
    h = cyc;
    i_sel_vio = 1'b1;
    push_exp(ID_SW,   h + 1,  8'd1);
    push_exp(ID_RST,  h + 1,  8'd1);
    push_exp(ID_CTRL, h + 8,  8'd1);
    push_exp(ID_SW,   h + 8,  8'd1);
    push_exp(ID_RST,  h + 8,  8'd1);
    push_exp(ID_SW,   h + 9,  8'd0);
    push_exp(ID_RST,  h + 9,  8'd0);
    push_exp(ID_CTRL, h + 9,  8'd1);
    push_exp(ID_CTRL, h + 10, 8'd3);
    push_exp(ID_SRC,  h + 10, 8'd1);
    step(15);

    // One-cycle VIO reset pulse: sys_reset high for 1 + 8 cycles.
    v = cyc;
    i_vio_reset = 1'b1;
    for (int k = 1; k <= 10; k++) push_exp(ID_RST, v + k, (k <= 9) ? 8'd1 : 8'd0);
    step(1);
    i_vio_reset = 1'b0;
    step(15);

    // VIO control latency and sticky status set / clear.
    s = cyc;
    i_vio_ctrl = 2'b10;
    i_stat     = 4'b1111;
    push_exp(ID_CTRL, s,     8'd3);
    push_exp(ID_CTRL, s + 1, 8'd2);
    push_exp(ID_LIVE, s + 1, 8'h0f);
    push_exp(ID_LOST, s + 3, 8'h00);
    step(3);
    i_stat = 4'b1011;
    push_exp(ID_LIVE, s + 3, 8'h0f);
    push_exp(ID_LOST, s + 4, 8'h04);
    push_exp(ID_LIVE, s + 4, 8'h0b);
    step(3);
    i_stat_clr = 1'b1;
    push_exp(ID_LOST, s + 6, 8'h04);
    push_exp(ID_LOST, s + 7, 8'h00);
    step(3);
    i_stat_clr = 1'b0;
    step(2);

    // Lost flag cleared by reset, and a drop during reset does not set it.
    i_stat = 4'b1111;
    step(3);
    y = cyc;
    i_stat = 4'b1101;
    push_exp(ID_LOST, y + 1, 8'h02);
    step(2);
    i_vio_reset = 1'b1;
    push_exp(ID_RST,  y + 3, 8'd1);
    push_exp(ID_LOST, y + 3, 8'h02);
    push_exp(ID_LOST, y + 4, 8'h00);
    step(1);
    i_vio_reset = 1'b0;
    step(2);
    i_stat = 4'b1001;
    push_exp(ID_LOST, y + 6,  8'h00);
    push_exp(ID_LIVE, y + 6,  8'h09);
    push_exp(ID_RST,  y + 11, 8'd1);
    push_exp(ID_RST,  y + 12, 8'd0);
    push_exp(ID_LOST, y + 14, 8'h00);
    step(12);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 50 && sb.size() != 0; k++) step(1);
    while (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s cycle %0d: never checked, want %0h", nm(sb[0].id), sb[0].cyc,
               sb[0].val);
      void'(sb.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
